// File: rtl/ecc_defines_pkg.sv
// ---------------------------------------------------------------------------
// ecc_defines_pkg
// Shared definitions for the ECC operand assembler:
//   - ecc_req_t          : 32-bit register-access request from the bus bridge
//   - ECC_OPND_WORDS     : number of 32-bit words in a 384-bit operand
//   - ecc_opnd_state_e   : per-slot load state (EMPTY / PARTIAL / FULL)
//   - ADDR_*             : bit positions of the window, slot-select and
//                          word-index fields inside req.addr
// ---------------------------------------------------------------------------
package ecc_defines_pkg;

    localparam int ECC_OPND_WORDS = 12;

    // addr[11:8] selects the operand window, addr[7:6] the slot and
    // addr[5:2] the 32-bit word; addr[1:0] carries no information.
    localparam int ADDR_WIN_HI  = 11;
    localparam int ADDR_WIN_LO  = 8;
    localparam int ADDR_SEL_HI  = 7;
    localparam int ADDR_SEL_LO  = 6;
    localparam int ADDR_WORD_HI = 5;
    localparam int ADDR_WORD_LO = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } ecc_opnd_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } ecc_req_t;

endpackage

// File: rtl/ecc_operand_slot.sv
// ---------------------------------------------------------------------------
// ecc_operand_slot
// One operand register with its word-completion mask and load state machine.
// Word 0 is the most significant 32 bits of the operand.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   zeroize      : synchronous clear of data, mask and state (highest priority)
//   wr_en        : accepted write to this slot (already qualified upstream)
//   word_idx     : word index of the write, 0 = most significant word
//   wdata        : write data
//   data         : stored operand
//   valid        : every word has been written since the last (re)start
//   done         : one-cycle pulse on the transition into FULL
// ---------------------------------------------------------------------------
module ecc_operand_slot
    import ecc_defines_pkg::*;
#(
    parameter int REG_SIZE = 384
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                wr_en,
    input  logic [3:0]          word_idx,
    input  logic [31:0]         wdata,
    output logic [REG_SIZE-1:0] data,
    output logic                valid,
    output logic                done
);

    localparam int NW = REG_SIZE / 32;

    ecc_opnd_state_e     state;
    ecc_opnd_state_e     state_nxt;
    logic [NW-1:0]       wmask;
    logic [NW-1:0]       wmask_nxt;
    logic [NW-1:0]       word_bit;
    logic [NW-1:0]       merged;
    logic [REG_SIZE-1:0] data_nxt;
    logic                done_nxt;

    always_comb begin
        state_nxt = state;
        wmask_nxt = wmask;
        data_nxt  = data;
        done_nxt  = 1'b0;
        word_bit  = '0;
        merged    = '0;

        for (int w = 0; w < NW; w++) begin
            if (int'(word_idx) == w) begin
                word_bit[w] = 1'b1;
                if (wr_en) begin
                    data_nxt[REG_SIZE-1-32*w -: 32] = wdata;
                end
            end
        end

        if (wr_en) begin
            // A write to an EMPTY or FULL slot starts a fresh load; only a
            // PARTIAL slot accumulates. Rewrites of a present word leave the
            // mask unchanged, so they never count twice.
            case (state)
                PARTIAL: merged = wmask | word_bit;
                default: merged = word_bit;
            endcase
            wmask_nxt = merged;
            if (&merged) begin
                state_nxt = FULL;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = PARTIAL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            wmask <= '0;
            data  <= '0;
            done  <= 1'b0;
        end else if (zeroize) begin
            state <= EMPTY;
            wmask <= '0;
            data  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            wmask <= wmask_nxt;
            data  <= data_nxt;
            done  <= done_nxt;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/ecc_operand_assembler.sv
// ---------------------------------------------------------------------------
// ecc_operand_assembler
// Assembles four operand registers (private key, message hash, public key X,
// public key Y) from the 32-bit ecc_req_t register stream, tracks per-operand
// completion, locks writes while the core is busy, and returns registered
// read-back data.
//
// Ports:
//   clk, reset_n   : clock and asynchronous active-low reset
//   zeroize        : synchronous clear of every operand; drops same-cycle request
//   req_dv         : request valid (one cycle per request)
//   req_data       : addr / wdata / write
//   core_busy      : core is consuming operands; writes are rejected
//   rdata          : read data, holds its value between reads
//   rdata_vld      : one-cycle read-data valid
//   err            : one-cycle request error (locked write or bad word index)
//   operand_o      : slot k occupies operand_o[k*REG_SIZE +: REG_SIZE]
//   operand_valid  : per-slot FULL flag
//   load_done      : per-slot one-cycle pulse when the slot becomes FULL
// ---------------------------------------------------------------------------
module ecc_operand_assembler
    import ecc_defines_pkg::*;
#(
    parameter int          REG_SIZE = 384,
    parameter int          NUM_OPND = 4,
    parameter logic [3:0]  WIN_BASE = 4'h1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         zeroize,
    input  logic                         req_dv,
    input  ecc_req_t                     req_data,
    input  logic                         core_busy,
    output logic [31:0]                  rdata,
    output logic                         rdata_vld,
    output logic                         err,
    output logic [NUM_OPND*REG_SIZE-1:0] operand_o,
    output logic [NUM_OPND-1:0]          operand_valid,
    output logic [NUM_OPND-1:0]          load_done
);

    localparam int NW = REG_SIZE / 32;

    logic [3:0]          win;
    logic [1:0]          sel;
    logic [3:0]          idx;
    logic                in_win;
    logic                idx_ok;
    logic                wr_ok;
    logic                rd_ok;
    logic                err_nxt;
    logic [31:0]         rd_word;
    logic [NUM_OPND-1:0] wr_en;
    logic [REG_SIZE-1:0] slot_data [NUM_OPND];
    logic                unused_addr_bits;

    assign win    = req_data.addr[ADDR_WIN_HI:ADDR_WIN_LO];
    assign sel    = req_data.addr[ADDR_SEL_HI:ADDR_SEL_LO];
    assign idx    = req_data.addr[ADDR_WORD_HI:ADDR_WORD_LO];
    assign unused_addr_bits = ^{req_data.addr[31:12], req_data.addr[1:0]};

    // Zeroize swallows any request in the same cycle, including its error.
    assign in_win = req_dv && (win == WIN_BASE) && !zeroize;
    assign idx_ok = (int'(idx) < NW);
    assign wr_ok  = in_win &&  req_data.write && !core_busy && idx_ok;
    assign rd_ok  = in_win && !req_data.write;
    assign err_nxt = in_win && (req_data.write ? (core_busy || !idx_ok) : !idx_ok);

    always_comb begin
        rd_word = '0;
        for (int w = 0; w < NW; w++) begin
            if (int'(idx) == w) begin
                rd_word = slot_data[sel][REG_SIZE-1-32*w -: 32];
            end
        end
    end

    for (genvar k = 0; k < NUM_OPND; k++) begin : g_slot
        assign wr_en[k] = wr_ok && (int'(sel) == k);

        ecc_operand_slot #(
            .REG_SIZE (REG_SIZE)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .zeroize  (zeroize),
            .wr_en    (wr_en[k]),
            .word_idx (idx),
            .wdata    (req_data.wdata),
            .data     (slot_data[k]),
            .valid    (operand_valid[k]),
            .done     (load_done[k])
        );

        assign operand_o[k*REG_SIZE +: REG_SIZE] = slot_data[k];
    end

    // Response register stage: request in cycle N answers in cycle N+1.
    // Read-back of key material is also cleared by zeroize.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata     <= '0;
            rdata_vld <= 1'b0;
            err       <= 1'b0;
        end else if (zeroize) begin
            rdata     <= '0;
            rdata_vld <= 1'b0;
            err       <= 1'b0;
        end else begin
            rdata_vld <= rd_ok;
            err       <= err_nxt;
            if (rd_ok) begin
                rdata <= idx_ok ? rd_word : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_ecc_operand_assembler.sv
// ---------------------------------------------------------------------------
// tb_ecc_operand_assembler
// Directed bench for ecc_operand_assembler: complete load, duplicate and
// out-of-order writes, write lock, bad index / window, re-arm, zeroize and
// asynchronous reset mid-load.
// ---------------------------------------------------------------------------
module tb_ecc_operand_assembler;
    import ecc_defines_pkg::*;

    localparam int REG_SIZE = 384;
    localparam int NUM_OPND = 4;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         zeroize;
    logic                         req_dv;
    ecc_req_t                     req_data;
    logic                         core_busy;
    logic [31:0]                  rdata;
    logic                         rdata_vld;
    logic                         err;
    logic [NUM_OPND*REG_SIZE-1:0] operand_o;
    logic [NUM_OPND-1:0]          operand_valid;
    logic [NUM_OPND-1:0]          load_done;

    int n_tests = 0;
    int n_fail  = 0;

    ecc_operand_assembler #(
        .REG_SIZE (REG_SIZE),
        .NUM_OPND (NUM_OPND),
        .WIN_BASE (4'h1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .zeroize       (zeroize),
        .req_dv        (req_dv),
        .req_data      (req_data),
        .core_busy     (core_busy),
        .rdata         (rdata),
        .rdata_vld     (rdata_vld),
        .err           (err),
        .operand_o     (operand_o),
        .operand_valid (operand_valid),
        .load_done     (load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; drives one request across the next posedge and
    // returns on the following negedge, where the response is visible.
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_dv         = 1'b1;
        req_data.addr  = a;
        req_data.wdata = d;
        req_data.write = w;
        @(negedge clk);
        req_dv   = 1'b0;
        req_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset_n   = 1'b0;
        zeroize   = 1'b0;
        req_dv    = 1'b0;
        req_data  = '0;
        core_busy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rdata_vld", {31'd0, rdata_vld}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_valid", {28'd0, operand_valid}, 32'd0);
        chk("rst_done", {28'd0, load_done}, 32'd0);
        chk("rst_operands", {31'd0, |operand_o}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Complete load of slot 0, word i = i+1
        for (int i = 0; i < 12; i++) begin
            req(1'b1, 32'h100 + 32'(4*i), 32'(i + 1));
            if (i < 11) chk("load0_early_done", {28'd0, load_done}, 32'd0);
        end
        chk("load0_done", {28'd0, load_done}, 32'h1);
        chk("load0_valid", {28'd0, operand_valid}, 32'h1);
        chk("load0_word0", operand_o[383:352], 32'd1);
        chk("load0_word11", operand_o[31:0], 32'd12);
        req(1'b0, 32'h114, 32'd0);
        chk("load0_done_pulse", {28'd0, load_done}, 32'd0);
        chk("read0_w5", rdata, 32'd6);
        chk("read0_w5_vld", {31'd0, rdata_vld}, 32'd1);
        chk("read0_w5_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("read_vld_pulse", {31'd0, rdata_vld}, 32'd0);

        // Slot 2: words 11, 11, then 0..10
        req(1'b1, 32'h1AC, 32'hAAAA_0000);
        req(1'b1, 32'h1AC, 32'hBBBB_0000);
        chk("dup_no_done", {28'd0, load_done}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            req(1'b1, 32'h180 + 32'(4*i), 32'h20 + 32'(i));
            if (i < 10) chk("ooo_early_done", {28'd0, load_done}, 32'd0);
        end
        chk("ooo_done", {28'd0, load_done}, 32'h4);
        chk("ooo_valid", {28'd0, operand_valid}, 32'h5);
        chk("ooo_word11", operand_o[799:768], 32'hBBBB_0000);
        req(1'b0, 32'h1A8, 32'd0);
        chk("raw_read_w10", rdata, 32'h2A);

        // Write lock
        core_busy = 1'b1;
        req(1'b1, 32'h1C0, 32'd5);
        chk("lock_err", {31'd0, err}, 32'd1);
        chk("lock_valid", {28'd0, operand_valid}, 32'h5);
        req(1'b0, 32'h1C0, 32'd0);
        chk("lock_read_vld", {31'd0, rdata_vld}, 32'd1);
        chk("lock_read_err", {31'd0, err}, 32'd0);
        chk("lock_read_data", rdata, 32'd0);
        req(1'b1, 32'h100, 32'hDEAD);
        chk("lock_full_err", {31'd0, err}, 32'd1);
        chk("lock_full_word0", operand_o[383:352], 32'd1);
        chk("lock_full_valid", {28'd0, operand_valid}, 32'h5);
        core_busy = 1'b0;
        @(negedge clk);
        chk("err_pulse", {31'd0, err}, 32'd0);

        // Bad index and window
        req(1'b0, 32'h104, 32'd0);
        chk("read0_w1", rdata, 32'd2);
        req(1'b1, 32'h130, 32'h1234);
        chk("badidx_wr_err", {31'd0, err}, 32'd1);
        chk("badidx_valid", {28'd0, operand_valid}, 32'h5);
        chk("badidx_word11", operand_o[31:0], 32'd12);
        req(1'b0, 32'h130, 32'd0);
        chk("badidx_rd_data", rdata, 32'd0);
        chk("badidx_rd_vld", {31'd0, rdata_vld}, 32'd1);
        chk("badidx_rd_err", {31'd0, err}, 32'd1);
        req(1'b1, 32'h230, 32'hFF);
        chk("win_wr_err", {31'd0, err}, 32'd0);
        chk("win_wr_valid", {28'd0, operand_valid}, 32'h5);
        req(1'b0, 32'h230, 32'd0);
        chk("win_rd_vld", {31'd0, rdata_vld}, 32'd0);

        // Re-arm slot 1
        for (int i = 0; i < 12; i++) req(1'b1, 32'h140 + 32'(4*i), 32'h100 + 32'(i));
        chk("slot1_valid", {28'd0, operand_valid}, 32'h7);
        req(1'b1, 32'h148, 32'h77);
        chk("rearm_valid", {28'd0, operand_valid}, 32'h5);
        chk("rearm_no_done", {28'd0, load_done}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i != 2) begin
                req(1'b1, 32'h140 + 32'(4*i), 32'h100 + 32'(i));
                if (i < 11) chk("rearm_early_done", {28'd0, load_done}, 32'd0);
            end
        end
        chk("rearm_done", {28'd0, load_done}, 32'h2);
        req(1'b0, 32'h148, 32'd0);
        chk("rearm_w2", rdata, 32'h77);
        req(1'b1, 32'h140, 32'h55);
        chk("hold_rdata", rdata, 32'h77);
        chk("slot1_partial", {28'd0, operand_valid}, 32'h5);

        // Zeroize with a concurrent write to 0x104
        zeroize = 1'b1;
        req(1'b1, 32'h104, 32'h99);
        zeroize = 1'b0;
        chk("zer_valid", {28'd0, operand_valid}, 32'd0);
        chk("zer_done", {28'd0, load_done}, 32'd0);
        chk("zer_err", {31'd0, err}, 32'd0);
        chk("zer_rdata_vld", {31'd0, rdata_vld}, 32'd0);
        chk("zer_rdata", rdata, 32'd0);
        chk("zer_operands", {31'd0, |operand_o}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i != 1) req(1'b1, 32'h100 + 32'(4*i), 32'(i + 1));
        end
        chk("zer_drop_done", {28'd0, load_done}, 32'd0);
        chk("zer_drop_valid", {28'd0, operand_valid}, 32'd0);
        req(1'b1, 32'h104, 32'd2);
        chk("refill_done", {28'd0, load_done}, 32'h1);

        // Same scenario with reset pulsed low mid-cycle
        req(1'b1, 32'h140, 32'h55);
        req(1'b0, 32'h100, 32'd0);
        chk("pre_rst_rdata", rdata, 32'd1);
        req_dv         = 1'b1;
        req_data.addr  = 32'h104;
        req_data.wdata = 32'h99;
        req_data.write = 1'b1;
        #2 reset_n = 1'b0;
        #1 chk("arst_immediate_valid", {28'd0, operand_valid}, 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        req_dv   = 1'b0;
        req_data = '0;
        chk("arst_valid", {28'd0, operand_valid}, 32'd0);
        chk("arst_done", {28'd0, load_done}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_rdata_vld", {31'd0, rdata_vld}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_operands", {31'd0, |operand_o}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i != 1) req(1'b1, 32'h100 + 32'(4*i), 32'(i + 1));
        end
        chk("arst_drop_done", {28'd0, load_done}, 32'd0);
        chk("arst_drop_valid", {28'd0, operand_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
